// File: rtl/mem_responder.sv
// Memory-side responder for fetch/load/store requests with fixed access latency and a
// code-protection check that blocks low-IP stores into the low address region.
module mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int PROT_K  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_src_ip,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              fault_irq,
  output logic [ADDR_W-1:0] fault_addr
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Two extra bits so PROT_K*4 and DEPTH never wrap against ADDR_W-wide operands
  localparam logic [ADDR_W+1:0] PROT_LIM  = (ADDR_W+2)'(PROT_K * 4);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]        CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;
  logic              viol_r;

  logic [ADDR_W-2:0] idx_s;
  logic              misaligned_s;
  logic              out_of_range_s;
  logic              src_prot_s;
  logic              dst_prot_s;
  logic              err_s;
  logic              viol_s;
  logic              access_s;
  logic              accept_s;
  logic              wr_en_s;
  logic [DATA_W-1:0] load_data_s;

  // Request classification; misaligned, then range, then protection
  always_comb begin
    idx_s          = req_addr[ADDR_W-1:1];
    misaligned_s   = req_addr[0];
    out_of_range_s = ({2'b00, idx_s} >= DEPTH_LIM);
    src_prot_s     = ({2'b00, req_src_ip} < PROT_LIM);
    dst_prot_s     = ({2'b00, req_addr} < PROT_LIM);
    accept_s       = (state_r == IDLE) && req_valid && req_ready;
    err_s          = 1'b0;
    viol_s         = 1'b0;
    access_s       = 1'b0;
    if (misaligned_s || out_of_range_s) begin
      err_s = 1'b1;
    end else if (req_we && src_prot_s && dst_prot_s) begin
      err_s  = 1'b1;
      viol_s = 1'b1;
    end else begin
      access_s = 1'b1;
    end
    wr_en_s = accept_s && access_s && req_we;
    if (access_s && !req_we) begin
      load_data_s = mem_r[idx_s[MEM_AW-1:0]];
    end else begin
      load_data_s = {DATA_W{1'b0}};
    end
  end

  // Word array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_s) begin
      mem_r[idx_s[MEM_AW-1:0]] <= req_wdata;
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      rdata_r    <= {DATA_W{1'b0}};
      err_r      <= 1'b0;
      viol_r     <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= {DATA_W{1'b0}};
      rsp_err    <= 1'b0;
      fault_irq  <= 1'b0;
      fault_addr <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            rdata_r   <= load_data_s;
            err_r     <= err_s;
            viol_r    <= viol_s;
            req_ready <= 1'b0;
            if (viol_s) begin
              fault_addr <= req_addr;
            end
            if (LATENCY == 1) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= load_data_s;
              rsp_err   <= err_s;
              fault_irq <= viol_s;
            end else begin
              state_r <= WAIT;
              cnt_r   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd1) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_r;
            rsp_err   <= err_r;
            fault_irq <= viol_r;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          // The interrupt marks only the first response cycle
          fault_irq <= 1'b0;
          if (rsp_ready) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= {DATA_W{1'b0}};
          rsp_err   <= 1'b0;
          fault_irq <= 1'b0;
        end
      endcase
    end
  end

endmodule
